// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive path: synchroniser, start qualification, mid-bit sampling, holding register.
module uart_receiver #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  i_clock,
  input  logic                  i_async_resetL,
  input  logic                  i_serial_in,
  input  logic                  i_read_ack,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_ready,
  output logic                  o_framing_error,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t                r_state, w_next_state;
  logic                  r_sync1, r_sync2;
  logic                  w_rx_s;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_ready, r_framing_error, r_overrun;
  logic                  w_cnt_clr, w_idx_clr, w_shift_en, w_load, w_drop, w_frame_err;

  assign w_rx_s = r_sync2;

  always_ff @(posedge i_clock or negedge i_async_resetL) begin
    if (!i_async_resetL) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
    end else begin
      r_sync1 <= i_serial_in;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_idx_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx_s) w_next_state = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_clr = 1'b1;
          if (!w_rx_s) begin
            w_next_state = S_DATA;
            w_idx_clr    = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == IDX_LAST) w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_next_state = S_IDLE;
            if (!r_data_ready || i_read_ack) w_load = 1'b1;
            else                              w_drop = 1'b1;
          end else begin
            w_frame_err  = 1'b1;
            w_next_state = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_rx_s) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Returning to IDLE mid stop bit lets a back-to-back start bit be caught.
  always_ff @(posedge i_clock or negedge i_async_resetL) begin
    if (!i_async_resetL) begin
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_data          <= '0;
      r_data_ready    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_cnt           <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      r_framing_error <= w_frame_err;
      if (w_idx_clr)       r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 1'b1;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
      if (w_load) begin
        r_data       <= r_shift;
        r_data_ready <= 1'b1;
        if (i_read_ack) r_overrun <= 1'b0;
      end else begin
        if (i_read_ack && r_data_ready) begin
          r_data_ready <= 1'b0;
          r_overrun    <= 1'b0;
        end
        if (w_drop) r_overrun <= 1'b1;
      end
    end
  end

  assign o_data          = r_data;
  assign o_data_ready    = r_data_ready;
  assign o_framing_error = r_framing_error;
  assign o_overrun       = r_overrun;
  assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver.
module tb_uart_receiver;

  logic       i_clock = 1'b0;
  logic       i_async_resetL;
  logic       i_serial_in;
  logic       i_read_ack;
  logic [7:0] o_data;
  logic       o_data_ready, o_framing_error, o_overrun, o_busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) dut (
    .i_clock        (i_clock),
    .i_async_resetL (i_async_resetL),
    .i_serial_in    (i_serial_in),
    .i_read_ack     (i_read_ack),
    .o_data         (o_data),
    .o_data_ready   (o_data_ready),
    .o_framing_error(o_framing_error),
    .o_overrun      (o_overrun),
    .o_busy         (o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the line to b and wait n rising edges; returns 1 time unit after the last edge.
  task automatic hold(input logic b, input int n);
    i_serial_in = b;
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  // Start + data + stop up to just after the stop-sample edge (frame-relative edge 155).
  task automatic send_to_stop(input logic [7:0] d, input logic stop_bit, input logic ack_at_stop);
    hold(1'b0, 16);
    for (int k = 0; k < 8; k++) hold(d[k], 16);
    hold(stop_bit, 10);
    i_read_ack = ack_at_stop;
    hold(stop_bit, 1);
    i_read_ack = 1'b0;
  endtask

  task automatic do_ack;
    i_read_ack = 1'b1;
    @(posedge i_clock);
    #1;
    i_read_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    i_async_resetL = 1'b0;
    i_serial_in    = 1'b1;
    i_read_ack     = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_data",  o_data, 8'h00);
    check("rst_ready", o_data_ready, 1'b0);
    check("rst_ferr",  o_framing_error, 1'b0);
    check("rst_ovr",   o_overrun, 1'b0);
    check("rst_busy",  o_busy, 1'b0);
    i_async_resetL = 1'b1;
    hold(1'b1, 10);

    // 0xA5 with exact output timing around the stop sample
    pat = 8'hA5;
    hold(1'b0, 4);
    check("a5_busy_early", o_busy, 1'b1);
    hold(1'b0, 12);
    for (int k = 0; k < 8; k++) hold(pat[k], 16);
    hold(1'b1, 10);
    check("a5_ready_before", o_data_ready, 1'b0);
    check("a5_busy_before",  o_busy, 1'b1);
    hold(1'b1, 1);
    check("a5_data",  o_data, 8'hA5);
    check("a5_ready", o_data_ready, 1'b1);
    check("a5_ferr",  o_framing_error, 1'b0);
    check("a5_ovr",   o_overrun, 1'b0);
    check("a5_busy",  o_busy, 1'b0);
    hold(1'b1, 5);
    do_ack;
    check("a5_ack_ready", o_data_ready, 1'b0);
    check("a5_ack_data",  o_data, 8'hA5);
    hold(1'b1, 10);

    // short low glitch aborts in START
    hold(1'b0, 4);
    check("glitch_busy_on", o_busy, 1'b1);
    hold(1'b1, 30);
    check("glitch_busy_off", o_busy, 1'b0);
    check("glitch_ready",    o_data_ready, 1'b0);
    check("glitch_ferr",     o_framing_error, 1'b0);

    // 0x3C with low stop bit, then a break
    send_to_stop(8'h3C, 1'b0, 1'b0);
    check("fe_pulse", o_framing_error, 1'b1);
    check("fe_data",  o_data, 8'hA5);
    check("fe_ready", o_data_ready, 1'b0);
    check("fe_busy",  o_busy, 1'b1);
    hold(1'b0, 1);
    check("fe_pulse_end", o_framing_error, 1'b0);
    hold(1'b0, 44);
    check("fe_wait_idle", o_busy, 1'b1);
    check("fe_no_repulse", o_framing_error, 1'b0);
    hold(1'b1, 20);
    check("fe_released", o_busy, 1'b0);
    send_to_stop(8'h5A, 1'b1, 1'b0);
    check("5a_data",  o_data, 8'h5A);
    check("5a_ready", o_data_ready, 1'b1);
    hold(1'b1, 5);
    do_ack;

    // back-to-back 0x11, 0x22 without ack
    send_to_stop(8'h11, 1'b1, 1'b0);
    check("11_data", o_data, 8'h11);
    hold(1'b1, 5);
    send_to_stop(8'h22, 1'b1, 1'b0);
    check("ovr_data",  o_data, 8'h11);
    check("ovr_ready", o_data_ready, 1'b1);
    check("ovr_flag",  o_overrun, 1'b1);
    hold(1'b1, 5);
    do_ack;
    check("ovr_ack_ready", o_data_ready, 1'b0);
    check("ovr_ack_flag",  o_overrun, 1'b0);
    hold(1'b1, 5);

    // ack coinciding with the stop sample of 0x77 while overrun is set
    send_to_stop(8'h66, 1'b1, 1'b0);
    hold(1'b1, 5);
    send_to_stop(8'h55, 1'b1, 1'b0);
    check("pre77_ovr",  o_overrun, 1'b1);
    check("pre77_data", o_data, 8'h66);
    hold(1'b1, 5);
    send_to_stop(8'h77, 1'b1, 1'b1);
    check("77_data",  o_data, 8'h77);
    check("77_ready", o_data_ready, 1'b1);
    check("77_ovr",   o_overrun, 1'b0);
    hold(1'b1, 5);

    // reset during data bit 3
    hold(1'b0, 16);
    hold(1'b0, 48);
    hold(1'b0, 8);
    check("rst_mid_busy_pre", o_busy, 1'b1);
    i_async_resetL = 1'b0;
    #2;
    check("rst_mid_data",  o_data, 8'h00);
    check("rst_mid_ready", o_data_ready, 1'b0);
    check("rst_mid_busy",  o_busy, 1'b0);
    check("rst_mid_ovr",   o_overrun, 1'b0);
    i_serial_in = 1'b1;
    #1;
    i_async_resetL = 1'b1;
    @(posedge i_clock);
    #1;
    hold(1'b1, 20);
    send_to_stop(8'hC3, 1'b1, 1'b0);
    check("c3_data",  o_data, 8'hC3);
    check("c3_ready", o_data_ready, 1'b1);
    check("c3_ovr",   o_overrun, 1'b0);
    hold(1'b1, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive path of the CPLD UART, the counterpart of the transmit shift datapath. It synchronises the asynchronous serial line, detects and qualifies the start bit, and samples each data bit at mid-bit. It then assembles the bits LSB-first into a word and checks the stop bit. Completed words are presented in a holding register with a ready/acknowledge handshake, plus framing-error and overrun flags, for the control unit.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 16, i_clock cycles per serial bit time. Must be even and ≥ 4.

Ports:
- i_clock  input  1  system clock; all state changes on its rising edge.
- i_async_resetL  input  1  reset, asynchronous, active-low.
- i_serial_in  input  1  asynchronous serial line; idle high.
- i_read_ack  input  1  consumer acknowledges the held word.
- o_data  output  DATA_WIDTH  holding register, LSB = first received data bit.
- o_data_ready  output  1  level; holding register contains an unread word.
- o_framing_error  output  1  one-cycle pulse; stop bit sampled low.
- o_overrun  output  1  sticky; a good frame was lost because o_data_ready was still set.
- o_busy  output  1  high in any state other than IDLE.

## Operation
- Input: two-flop synchroniser on i_serial_in, both flops reset to 1. All logic uses the second flop output (rx_s).
- Bit counter is log2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1. The bit index counter is log2(DATA_WIDTH)+1 bits wide.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rx_s = 0, go to START and clear the counter.
  - START: at counter = CLKS_PER_BIT/2-1, sample rx_s.
    - If 0, the start bit is valid: go to DATA, clear the counter and the bit index.
    - If 1, it was a glitch: go to IDLE. No flags are raised.
  - DATA: at counter = CLKS_PER_BIT-1, sample rx_s into the MSB of the shift register. The register shifts right, so the first bit ends in bit 0. Increment the bit index and clear the counter. After the DATA_WIDTH-th sample, go to STOP.
  - STOP: at counter = CLKS_PER_BIT-1, sample rx_s.
    - If 1 and o_data_ready = 0, or i_read_ack is high that same cycle: load o_data from the shift register, set o_data_ready, go to IDLE.
    - If 1 and o_data_ready = 1 with no ack: discard the word, keep the old o_data, set o_overrun, go to IDLE.
    - If 0: pulse o_framing_error, discard the word, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This handles a break condition without re-triggering.
- Handshake: when i_read_ack = 1 and o_data_ready = 1, o_data_ready and o_overrun are cleared next cycle. An ack while o_data_ready = 0 is ignored. o_data holds its value after ack until the next load.
- Simultaneous ack and good stop sample: the new word is loaded, o_data_ready stays 1, and o_overrun is cleared (not set).
- Reset while in any state returns all state, counters and outputs to reset values immediately. A partial frame is lost.
- Reset values: o_data = 0, o_data_ready = 0, o_framing_error = 0, o_overrun = 0, o_busy = 0, FSM = IDLE, shift register = 0.

## Timing
- Let t0 be the first edge at which rx_s = 0 in IDLE. The line falling edge precedes t0 by 2–3 cycles because of the synchroniser.
- START is entered at t0+1.
- Start sample occurs at t0+CLKS_PER_BIT/2.
- Data bit k (k = 0..DATA_WIDTH-1) is sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- Stop sample occurs at t0+CLKS_PER_BIT/2+(DATA_WIDTH+1)·CLKS_PER_BIT.
- o_data, o_data_ready, o_framing_error and o_overrun are registered and change one cycle after the stop sample.
- o_framing_error is exactly one cycle wide.
- o_busy rises one cycle after t0 and falls on entry to IDLE.
- Back-to-back frames: a start bit that immediately follows the stop bit is detected, because IDLE is re-entered mid stop bit.
- Tolerated baud mismatch is about ±4% with the default parameters.

## Test plan
All scenarios use DATA_WIDTH = 8 and CLKS_PER_BIT = 16.
- Send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with a valid stop bit → o_data = 0xA5 and o_data_ready = 1 at stop sample +1. o_framing_error and o_overrun stay 0. i_read_ack clears ready the next cycle.
- Pull the line low for 4 cycles, then high → START aborts at the mid-bit sample. o_busy returns to 0 and o_data_ready never rises.
- Send 0x3C with the stop bit low, holding the line low for 40 more cycles → one-cycle o_framing_error, o_data unchanged, FSM held in WAIT_IDLE. A following valid 0x5A frame is received correctly.
- Send 0x11 then 0x22 back-to-back with no ack → o_data = 0x11 and o_overrun = 1 after the second frame. An ack clears both flags.
- Send 0x77 with o_data_ready already set, asserting i_read_ack on the stop-sample cycle → o_data = 0x77, o_data_ready = 1, o_overrun = 0.
- Assert i_async_resetL low during data bit 3 of a frame → all outputs return to reset values immediately. The next full frame, 0xC3, is received correctly.
